// File: rtl/btn_pulse_conditioner.sv
// Push-button conditioner: synchronizes a raw button and the divided slowclk,
// debounces on slowclk rising-edge ticks and emits press/release/auto-repeat pulses.
module btn_pulse_conditioner #(
  parameter int DEPTH        = 4,
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 4,
  parameter int CNT_W        = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic slowclk,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEAT    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
  localparam logic [CNT_W-1:0] REP_LAST =
    CNT_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

  logic             btn_m;
  logic             btn_s;
  logic             s0;
  logic             s1;
  logic             s2;
  logic             tick;
  logic [DEPTH-1:0] shreg;
  logic [DEPTH-1:0] shreg_nxt;
  logic             press_ev;
  logic             release_ev;
  logic             repeat_ev;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // slowclk is sampled as data; the third flop gives a one-cycle rising-edge tick
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      s0    <= 1'b0;
      s1    <= 1'b0;
      s2    <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      s0    <= slowclk;
      s1    <= s0;
      s2    <= s1;
    end
  end

  assign tick = s1 & ~s2;

  always_comb begin
    shreg_nxt = shreg;
    if (tick) shreg_nxt = {shreg[DEPTH-2:0], btn_s};
  end

  assign press_ev   = tick & (&shreg_nxt) & ~btn_level;
  assign release_ev = tick & ~(|shreg_nxt) & btn_level;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shreg         <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      shreg         <= shreg_nxt;
      press_pulse   <= press_ev;
      release_pulse <= release_ev;
      repeat_pulse  <= repeat_ev;
      if (press_ev)        btn_level <= 1'b1;
      else if (release_ev) btn_level <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Release is checked before the repeat compare so it wins on a shared tick
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    repeat_ev = 1'b0;
    case (state)
      IDLE: begin
        if (press_ev && (HOLD_TICKS != 0)) begin
          state_nxt = HOLD_WAIT;
          cnt_nxt   = '0;
        end
      end
      HOLD_WAIT: begin
        if (release_ev) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (tick) begin
          if (cnt == HOLD_LAST) begin
            repeat_ev = 1'b1;
            cnt_nxt   = '0;
            state_nxt = REPEAT;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      REPEAT: begin
        if (release_ev) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (tick) begin
          if (cnt == REP_LAST) begin
            repeat_ev = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// Scoreboard bench: stimulus queues expected pulses tagged with the slowclk rise
// that should produce them; a negedge monitor pops and checks kind, timing and level.
module tb_btn_pulse_conditioner;

  logic clock;
  logic resetn;
  logic slowclk;
  logic btn;
  logic btn0;
  logic lvl, prs, rel, rep;
  logic lvl0, prs0, rel0, rep0;

  typedef struct {
    logic [5:0] kind;
    int         rise;
  } exp_t;

  exp_t q[$];
  int   rise_cyc[512];
  int   rise_cnt;
  int   cyc;
  int   checks;
  int   errors;

  localparam logic [5:0] K_PRS  = 6'b000001;
  localparam logic [5:0] K_REL  = 6'b000010;
  localparam logic [5:0] K_REP  = 6'b000100;
  localparam logic [5:0] K_PRS0 = 6'b001000;
  localparam logic [5:0] K_REL0 = 6'b010000;
  localparam logic [5:0] K_REP0 = 6'b100000;

  btn_pulse_conditioner dut (
    .clock(clock), .resetn(resetn), .slowclk(slowclk), .btn(btn),
    .btn_level(lvl), .press_pulse(prs), .release_pulse(rel), .repeat_pulse(rep)
  );

  btn_pulse_conditioner #(.HOLD_TICKS(0)) dut0 (
    .clock(clock), .resetn(resetn), .slowclk(slowclk), .btn(btn0),
    .btn_level(lvl0), .press_pulse(prs0), .release_pulse(rel0), .repeat_pulse(rep0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(input logic [5:0] kind, input int rise);
    exp_t e;
    e.kind = kind;
    e.rise = rise;
    q.push_back(e);
  endtask

  // One 8-clock slowclk period; returns 3 negedges after the rise, when its tick has resolved
  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clock);
      slowclk = 1'b0;
      repeat (4) @(negedge clock);
      slowclk = 1'b1;
      rise_cnt++;
      rise_cyc[rise_cnt] = cyc;
      repeat (3) @(negedge clock);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},    {31'd0, lvl},  0);
    chk({tag, "_press"},    {31'd0, prs},  0);
    chk({tag, "_release"},  {31'd0, rel},  0);
    chk({tag, "_repeat"},   {31'd0, rep},  0);
    chk({tag, "_level0"},   {31'd0, lvl0}, 0);
    chk({tag, "_press0"},   {31'd0, prs0}, 0);
    chk({tag, "_release0"}, {31'd0, rel0}, 0);
    chk({tag, "_repeat0"},  {31'd0, rep0}, 0);
  endtask

  // Monitor
  initial begin
    logic [5:0] pulses;
    exp_t       e;
    forever begin
      @(negedge clock);
      pulses = {rep0, rel0, prs0, rep, rel, prs};
      if (pulses != 6'b0) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {26'd0, pulses}, 0);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", {26'd0, pulses}, {26'd0, e.kind});
          chk("pulse_cycle", cyc, rise_cyc[e.rise] + 3);
          if (e.kind[0] || e.kind[1]) chk("level_at_edge", {31'd0, lvl}, {31'd0, e.kind[0]});
          if (e.kind[3] || e.kind[4]) chk("level0_at_edge", {31'd0, lvl0}, {31'd0, e.kind[3]});
        end
      end
    end
  end

  initial begin
    int r;
    checks   = 0;
    errors   = 0;
    rise_cnt = 0;
    for (int i = 0; i < 512; i++) rise_cyc[i] = 0;
    resetn  = 1'b0;
    btn     = 1'b0;
    btn0    = 1'b0;
    slowclk = 1'b0;
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    #2 resetn = 1'b1;
    ticks(4);

    // Clean press, hold with repeats, release on the tick a repeat falls due
    r = rise_cnt;
    expect_ev(K_PRS, r + 4);
    expect_ev(K_REP, r + 12);
    expect_ev(K_REP, r + 16);
    expect_ev(K_REP, r + 20);
    expect_ev(K_REP, r + 24);
    expect_ev(K_REL, r + 28);
    btn = 1'b1;
    ticks(24);
    btn = 1'b0;
    ticks(10);

    // Bounce 1,0,1,0 then steady 1; release while still in the hold wait
    r = rise_cnt;
    expect_ev(K_PRS, r + 8);
    expect_ev(K_REL, r + 13);
    btn = 1'b1; ticks(1);
    btn = 1'b0; ticks(1);
    btn = 1'b1; ticks(1);
    btn = 1'b0; ticks(1);
    btn = 1'b1; ticks(5);
    btn = 1'b0; ticks(8);

    // Repeat disabled instance held for 50 ticks
    r = rise_cnt;
    expect_ev(K_PRS0, r + 4);
    expect_ev(K_REL0, r + 54);
    btn0 = 1'b1;
    ticks(50);
    btn0 = 1'b0;
    ticks(8);

    // Asynchronous reset in the middle of repeating
    r = rise_cnt;
    expect_ev(K_PRS, r + 4);
    expect_ev(K_REP, r + 12);
    expect_ev(K_REP, r + 16);
    btn = 1'b1;
    ticks(17);
    chk("level_before_reset", {31'd0, lvl}, 1);
    #3 resetn = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clock);
    slowclk = 1'b0;
    repeat (3) @(negedge clock);
    #2 resetn = 1'b1;
    r = rise_cnt;
    expect_ev(K_PRS, r + 4);
    ticks(6);

    // slowclk stopped: release must not be seen and no repeat may fire
    repeat (100) @(negedge clock);
    btn = 1'b0;
    repeat (100) @(negedge clock);
    chk("frozen_level", {31'd0, lvl}, 1);
    r = rise_cnt;
    expect_ev(K_REL, r + 4);
    ticks(8);

    chk("pending_expected", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
